// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and the decode bundle passed from mc_decode to the FSM.
package mc_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 7'b1100011;
    localparam logic [XLEN-1:0]  EBREAK  = 32'h0010_0073;

    localparam logic [F3_W-1:0]  F3_WORD = 3'b010;
    localparam logic [F3_W-1:0]  F3_BEQ  = 3'b000;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1101;

    typedef struct packed {
        logic             is_r;
        logic             is_i;
        logic             is_lw;
        logic             is_sw;
        logic             is_beq;
        logic             illegal;
        logic             alu_src;
        logic [ALU_W-1:0] alu_ctrl;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into instruction class flags,
// ALU operation and operand-B select; anything unsupported raises illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [F3_W-1:0]  i_funct3,
    input  logic             i_funct7b5,
    output dec_t             o_dec_c
);

    always_comb begin
        o_dec_c          = '0;
        o_dec_c.alu_ctrl = ALU_ADD;
        case (i_opcode)
            OP_R, OP_I: begin
                o_dec_c.is_r    = (i_opcode == OP_R);
                o_dec_c.is_i    = (i_opcode == OP_I);
                o_dec_c.alu_src = (i_opcode == OP_I);
                case (i_funct3)
                    3'b000: o_dec_c.alu_ctrl = ((i_opcode == OP_R) && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111: o_dec_c.alu_ctrl = ALU_AND;
                    3'b110: o_dec_c.alu_ctrl = ALU_OR;
                    3'b100: o_dec_c.alu_ctrl = ALU_XOR;
                    3'b010: o_dec_c.alu_ctrl = ALU_SLT;
                    3'b001: o_dec_c.alu_ctrl = ALU_SLL;
                    3'b101: o_dec_c.alu_ctrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    default: o_dec_c.illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                o_dec_c.is_lw   = 1'b1;
                o_dec_c.alu_src = 1'b1;
                o_dec_c.illegal = (i_funct3 != F3_WORD);
            end
            OP_SW: begin
                o_dec_c.is_sw   = 1'b1;
                o_dec_c.alu_src = 1'b1;
                o_dec_c.illegal = (i_funct3 != F3_WORD);
            end
            OP_BEQ: begin
                o_dec_c.is_beq   = 1'b1;
                o_dec_c.alu_ctrl = ALU_SUB;
                o_dec_c.illegal  = (i_funct3 != F3_BEQ);
            end
            default: o_dec_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control unit for the RV32I core. All datapath and
// memory strobes are registered Moore outputs of the state they belong to.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     instr,
    input  logic                Zero,
    output logic                ALUSrc,
    output logic [ALU_W-1:0]    ALUCtrl,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                loadPC,
    output logic                PCSrc,
    output logic                halted,
    output logic [STATE_W-1:0]  state,
    output logic [RETIRE_W-1:0] retired
);

    state_t              r_state;
    logic [OPC_W-1:0]    r_opcode;
    logic [F3_W-1:0]     r_funct3;
    logic                r_funct7b5;
    logic                r_ebreak;
    logic                r_branch_taken;
    logic                r_alu_src;
    logic [ALU_W-1:0]    r_alu_ctrl;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_mem_to_reg;
    logic                r_reg_write;
    logic                r_load_pc;
    logic                r_pc_src;
    logic                r_halted;
    logic [RETIRE_W-1:0] r_retired;

    logic [OPC_W-1:0]    w_opcode;
    logic [F3_W-1:0]     w_funct3;
    logic                w_funct7b5;
    logic                w_halt;
    dec_t                w_dec;

    // During ID the decoder looks at the fields about to be latched so the EX
    // outputs can be registered on the same edge; afterwards only the latch counts.
    assign w_opcode   = (r_state == ST_ID) ? instr[6:0]   : r_opcode;
    assign w_funct3   = (r_state == ST_ID) ? instr[14:12] : r_funct3;
    assign w_funct7b5 = (r_state == ST_ID) ? instr[30]    : r_funct7b5;
    assign w_halt     = w_dec.illegal | r_ebreak;

    mc_decode u_decode (
        .i_opcode   (w_opcode),
        .i_funct3   (w_funct3),
        .i_funct7b5 (w_funct7b5),
        .o_dec_c    (w_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IF;
            r_opcode       <= OP_I;
            r_funct3       <= 3'b000;
            r_funct7b5     <= 1'b0;
            r_ebreak       <= 1'b0;
            r_branch_taken <= 1'b0;
            r_alu_src      <= 1'b0;
            r_alu_ctrl     <= ALU_ADD;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_reg_write    <= 1'b0;
            r_load_pc      <= 1'b0;
            r_pc_src       <= 1'b0;
            r_halted       <= 1'b0;
            r_retired      <= '0;
        end else begin
            case (r_state)
                ST_IF: r_state <= ST_ID;
                ST_ID: begin
                    r_opcode   <= instr[6:0];
                    r_funct3   <= instr[14:12];
                    r_funct7b5 <= instr[30];
                    r_ebreak   <= (instr == EBREAK);
                    r_alu_ctrl <= w_dec.alu_ctrl;
                    r_alu_src  <= w_dec.alu_src;
                    r_state    <= ST_EX;
                end
                ST_EX: begin
                    if (w_halt) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_alu_src  <= 1'b0;
                        r_alu_ctrl <= ALU_ADD;
                    end else begin
                        r_state        <= ST_MEM;
                        r_branch_taken <= w_dec.is_beq & Zero;
                        r_mem_read     <= w_dec.is_lw;
                        r_mem_write    <= w_dec.is_sw;
                    end
                end
                ST_MEM: begin
                    r_state      <= ST_WB;
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_reg_write  <= w_dec.is_r | w_dec.is_i | w_dec.is_lw;
                    r_mem_to_reg <= w_dec.is_lw;
                    r_load_pc    <= 1'b1;
                    r_pc_src     <= r_branch_taken;
                end
                ST_WB: begin
                    r_state        <= ST_IF;
                    r_reg_write    <= 1'b0;
                    r_mem_to_reg   <= 1'b0;
                    r_load_pc      <= 1'b0;
                    r_pc_src       <= 1'b0;
                    r_branch_taken <= 1'b0;
                    r_alu_src      <= 1'b0;
                    r_alu_ctrl     <= ALU_ADD;
                    r_retired      <= r_retired + RETIRE_W'(1);
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IF;
            endcase
        end
    end

    assign ALUSrc   = r_alu_src;
    assign ALUCtrl  = r_alu_ctrl;
    assign MemRead  = r_mem_read;
    assign MemWrite = r_mem_write;
    assign MemToReg = r_mem_to_reg;
    assign RegWrite = r_reg_write;
    assign loadPC   = r_load_pc;
    assign PCSrc    = r_pc_src;
    assign halted   = r_halted;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule
